amm_mem_slave: RTL and testbench

// - Avalon-MM burst slave backed by on-chip RAM; the responder end of the amm_if master port.
// - Serves as the memory target for the checker's traffic master, in simulation and on FPGA.
// - Supports burst writes with byteenable, pipelined burst reads with fixed latency, and waitrequest backpressure.

---
 rtl/amm_slave_pkg.sv | 15 +
 rtl/amm_be_ram.sv | 34 +++
 rtl/amm_mem_slave.sv | 123 ++++++++++++
 tb/tb_amm_mem_slave.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/amm_slave_pkg.sv
// Shared types and helpers for the Avalon-MM RAM-backed burst slave.
package amm_slave_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_BURST = 2'd2
    } state_t;

    // A burstcount of zero is treated as a single-beat transfer.
    function automatic logic [31:0] norm_burst(input logic [31:0] burstcount);
        return (burstcount == 32'd0) ? 32'd1 : burstcount;
    endfunction

endpackage

// File: rtl/amm_be_ram.sv
// Simple dual-port RAM with byte-lane write enables and a one-cycle registered read.
module amm_be_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data
);

    localparam int BYTES = DATA_W / 8;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Contents are deliberately not reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < BYTES; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
                end
            end
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/amm_mem_slave.sv
// Avalon-MM burst slave: burst writes with byteenable, pipelined fixed-latency burst reads.
module amm_mem_slave
    import amm_slave_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int BURST_W    = 11,
    parameter int MEM_ADDR_W = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   amm_address,
    input  logic                amm_read,
    input  logic                amm_write,
    input  logic [DATA_W/8-1:0] amm_byteenable,
    input  logic [BURST_W-1:0]  amm_burstcount,
    input  logic [DATA_W-1:0]   amm_writedata,
    output logic [DATA_W-1:0]   amm_readdata,
    output logic                amm_readdatavalid,
    output logic                amm_waitrequest,
    output logic                proto_err
);

    state_t                state_q, state_n;
    logic [MEM_ADDR_W-1:0] addr_q, addr_n;
    logic [BURST_W-1:0]    rem_q, rem_n;
    logic                  rdv_q;
    logic                  proto_q, proto_n;

    logic                  ram_we, ram_re;
    logic [MEM_ADDR_W-1:0] ram_waddr, ram_raddr;
    logic [DATA_W-1:0]     ram_q;
    logic [MEM_ADDR_W-1:0] base;
    logic [BURST_W-1:0]    burst_eff;
    logic                  unused_addr_hi;

    // Upper address bits alias onto the RAM.
    assign base           = amm_address[MEM_ADDR_W-1:0];
    assign unused_addr_hi = ^amm_address[ADDR_W-1:MEM_ADDR_W];
    assign burst_eff      = BURST_W'(norm_burst(32'(amm_burstcount)));

    assign amm_waitrequest   = rst || (state_q == RD_BURST);
    assign amm_readdatavalid = rdv_q && !rst;
    assign amm_readdata      = amm_readdatavalid ? ram_q : '0;
    assign proto_err         = proto_q;

    always_comb begin
        state_n   = state_q;
        addr_n    = addr_q;
        rem_n     = rem_q;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_waddr = addr_q;
        ram_raddr = addr_q;
        proto_n   = proto_q | (amm_read && (amm_write || state_q == WR_BURST));
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    // Write wins over a simultaneous read; the read is dropped.
                    if (amm_write || amm_read) begin
                        addr_n = base + MEM_ADDR_W'(1);
                        rem_n  = burst_eff - BURST_W'(1);
                        if (amm_write) begin
                            ram_we    = 1'b1;
                            ram_waddr = base;
                            if (burst_eff > BURST_W'(1)) state_n = WR_BURST;
                        end else begin
                            ram_re    = 1'b1;
                            ram_raddr = base;
                            if (burst_eff > BURST_W'(1)) state_n = RD_BURST;
                        end
                    end
                end
                WR_BURST: begin
                    if (amm_write) begin
                        ram_we = 1'b1;
                        addr_n = addr_q + MEM_ADDR_W'(1);
                        rem_n  = rem_q - BURST_W'(1);
                        if (rem_q == BURST_W'(1)) state_n = IDLE;
                    end
                end
                RD_BURST: begin
                    ram_re = 1'b1;
                    addr_n = addr_q + MEM_ADDR_W'(1);
                    rem_n  = rem_q - BURST_W'(1);
                    if (rem_q == BURST_W'(1)) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            rdv_q   <= 1'b0;
            proto_q <= 1'b0;
        end else begin
            state_q <= state_n;
            addr_q  <= addr_n;
            rem_q   <= rem_n;
            rdv_q   <= ram_re;
            proto_q <= proto_n;
        end
    end

    amm_be_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (MEM_ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (ram_waddr),
        .wr_be   (amm_byteenable),
        .wr_data (amm_writedata),
        .rd_en   (ram_re),
        .rd_addr (ram_raddr),
        .rd_data (ram_q)
    );

endmodule

// File: tb/tb_amm_mem_slave.sv
// Directed self-checking bench for amm_mem_slave with hand-computed expectations.
module tb_amm_mem_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] amm_address;
    logic        amm_read, amm_write;
    logic [3:0]  amm_byteenable;
    logic [10:0] amm_burstcount;
    logic [31:0] amm_writedata;
    logic [31:0] amm_readdata;
    logic        amm_readdatavalid, amm_waitrequest, proto_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    amm_mem_slave dut (
        .clk               (clk),
        .rst               (rst),
        .amm_address       (amm_address),
        .amm_read          (amm_read),
        .amm_write         (amm_write),
        .amm_byteenable    (amm_byteenable),
        .amm_burstcount    (amm_burstcount),
        .amm_writedata     (amm_writedata),
        .amm_readdata      (amm_readdata),
        .amm_readdatavalid (amm_readdatavalid),
        .amm_waitrequest   (amm_waitrequest),
        .proto_err         (proto_err)
    );

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        amm_read = 1'b0; amm_write = 1'b0; amm_byteenable = 4'hF;
        amm_burstcount = 11'd1; amm_address = '0; amm_writedata = '0;
    endtask

    task automatic single_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
        amm_write = 1'b1; amm_address = a; amm_writedata = d;
        amm_byteenable = be; amm_burstcount = 11'd1;
        tick();
        idle_bus();
    endtask

    task automatic test_reset();
        idle_bus();
        rst = 1'b1;
        tick(); tick();
        tests++; if (amm_readdatavalid !== 1'b0) begin fails++; $display("FAIL reset_rdv got=%b exp=0", amm_readdatavalid); end
        tests++; if (amm_readdata !== 32'h0) begin fails++; $display("FAIL reset_rdata got=%h exp=0", amm_readdata); end
        tests++; if (amm_waitrequest !== 1'b1) begin fails++; $display("FAIL reset_wait got=%b exp=1", amm_waitrequest); end
        tests++; if (proto_err !== 1'b0) begin fails++; $display("FAIL reset_proto got=%b exp=0", proto_err); end
        rst = 1'b0;
        #1;
        tests++; if (amm_waitrequest !== 1'b0) begin fails++; $display("FAIL post_reset_wait got=%b exp=0", amm_waitrequest); end
    endtask

    task automatic test_single();
        single_write(16'h0010, 32'hDEADBEEF, 4'hF);
        amm_read = 1'b1; amm_address = 16'h0010; amm_burstcount = 11'd1;
        #1;
        tests++; if (amm_waitrequest !== 1'b0) begin fails++; $display("FAIL single_wait_T got=%b exp=0", amm_waitrequest); end
        tick();
        idle_bus();
        tests++; if (amm_readdatavalid !== 1'b1) begin fails++; $display("FAIL single_rdv got=%b exp=1", amm_readdatavalid); end
        tests++; if (amm_readdata !== 32'hDEADBEEF) begin fails++; $display("FAIL single_rdata got=%h exp=deadbeef", amm_readdata); end
        tests++; if (amm_waitrequest !== 1'b0) begin fails++; $display("FAIL single_wait_T1 got=%b exp=0", amm_waitrequest); end
        tick();
        tests++; if (amm_readdatavalid !== 1'b0) begin fails++; $display("FAIL single_rdv_end got=%b exp=0", amm_readdatavalid); end
    endtask

    task automatic test_wrap_burst();
        amm_write = 1'b1; amm_address = 16'h03FE; amm_burstcount = 11'd4; amm_byteenable = 4'hF;
        for (int i = 1; i <= 4; i++) begin
            amm_writedata = 32'(i);
            tick();
            amm_address = 16'h7777; amm_burstcount = 11'd9;
        end
        idle_bus();
        amm_read = 1'b1; amm_address = 16'h03FE; amm_burstcount = 11'd4;
        tick();
        idle_bus();
        for (int i = 1; i <= 4; i++) begin
            tests++; if (amm_readdatavalid !== 1'b1 || amm_readdata !== 32'(i)) begin
                fails++; $display("FAIL burst_rd beat%0d got=%b/%h exp=1/%h", i, amm_readdatavalid, amm_readdata, 32'(i)); end
            tests++; if (amm_waitrequest !== (i < 4)) begin
                fails++; $display("FAIL burst_wait beat%0d got=%b exp=%b", i, amm_waitrequest, (i < 4)); end
            tick();
        end
        tests++; if (amm_readdatavalid !== 1'b0) begin fails++; $display("FAIL burst_rdv_end got=%b exp=0", amm_readdatavalid); end
        // 0x400 aliases to 0x000, the third beat of the wrapped burst
        amm_read = 1'b1; amm_address = 16'h0400;
        tick();
        idle_bus();
        tests++; if (amm_readdata !== 32'd3) begin fails++; $display("FAIL alias_rd got=%h exp=3", amm_readdata); end
    endtask

    task automatic test_byteenable();
        single_write(16'h0020, 32'hFFFFFFFF, 4'hF);
        single_write(16'h0020, 32'h12345678, 4'b0101);
        amm_read = 1'b1; amm_address = 16'h0020;
        tick();
        idle_bus();
        tests++; if (amm_readdata !== 32'hFF34FF78) begin fails++; $display("FAIL byteen_rd got=%h exp=ff34ff78", amm_readdata); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            amm_write = 1'b1; amm_address = 16'h0100 + 16'(i); amm_writedata = 32'hA000 + 32'(i);
            tick();
        end
        idle_bus();
        for (int i = 0; i < 16; i++) begin
            amm_read = 1'b1; amm_address = 16'h0100 + 16'(i);
            #1;
            tests++; if (amm_waitrequest !== 1'b0) begin fails++; $display("FAIL b2b_wait i=%0d got=%b exp=0", i, amm_waitrequest); end
            tick();
            tests++; if (amm_readdatavalid !== 1'b1 || amm_readdata !== 32'hA000 + 32'(i)) begin
                fails++; $display("FAIL b2b_rd i=%0d got=%b/%h exp=1/%h", i, amm_readdatavalid, amm_readdata, 32'hA000 + 32'(i)); end
        end
        idle_bus();
        tick();
        tests++; if (amm_readdatavalid !== 1'b0) begin fails++; $display("FAIL b2b_rdv_end got=%b exp=0", amm_readdatavalid); end
        // burstcount 0 is one beat: the following write must not land at 0x201
        single_write(16'h0201, 32'h66, 4'hF);
        amm_write = 1'b1; amm_address = 16'h0200; amm_burstcount = 11'd0; amm_writedata = 32'h77;
        tick();
        amm_address = 16'h0300; amm_burstcount = 11'd1; amm_writedata = 32'h99;
        tick();
        idle_bus();
        amm_read = 1'b1; amm_address = 16'h0201;
        tick();
        tests++; if (amm_readdata !== 32'h66) begin fails++; $display("FAIL bc0_next got=%h exp=66", amm_readdata); end
        amm_address = 16'h0200;
        tick();
        tests++; if (amm_readdata !== 32'h77) begin fails++; $display("FAIL bc0_beat got=%h exp=77", amm_readdata); end
        amm_address = 16'h0300;
        tick();
        idle_bus();
        tests++; if (amm_readdata !== 32'h99) begin fails++; $display("FAIL bc0_follow got=%h exp=99", amm_readdata); end
    endtask

    task automatic test_gap_proto();
        amm_write = 1'b1; amm_address = 16'h0040; amm_burstcount = 11'd8;
        for (int i = 0; i < 8; i++) begin
            amm_writedata = 32'hB0 + 32'(i);
            tick();
            if (i == 2) begin
                amm_write = 1'b0;
                tick();
                amm_read = 1'b1; amm_address = 16'h0010; amm_burstcount = 11'd1;
                tick();
                amm_read = 1'b0;
                tests++; if (proto_err !== 1'b1) begin fails++; $display("FAIL gap_proto got=%b exp=1", proto_err); end
                tick();
                tests++; if (amm_readdatavalid !== 1'b0) begin fails++; $display("FAIL gap_rdv got=%b exp=0", amm_readdatavalid); end
                amm_write = 1'b1;
            end
        end
        idle_bus();
        amm_read = 1'b1; amm_address = 16'h0040; amm_burstcount = 11'd8;
        tick();
        idle_bus();
        for (int i = 0; i < 8; i++) begin
            tests++; if (amm_readdatavalid !== 1'b1 || amm_readdata !== 32'hB0 + 32'(i)) begin
                fails++; $display("FAIL gap_rd beat%0d got=%b/%h exp=1/%h", i, amm_readdatavalid, amm_readdata, 32'hB0 + 32'(i)); end
            tick();
        end
        tests++; if (proto_err !== 1'b1) begin fails++; $display("FAIL proto_sticky got=%b exp=1", proto_err); end
    endtask

    task automatic test_reset_mid_burst();
        amm_read = 1'b1; amm_address = 16'h0040; amm_burstcount = 11'd8;
        tick();
        idle_bus();
        tests++; if (amm_readdata !== 32'hB0) begin fails++; $display("FAIL rstb_beat0 got=%h exp=b0", amm_readdata); end
        tick(); tick();
        rst = 1'b1;
        #1;
        tests++; if (amm_readdatavalid !== 1'b0) begin fails++; $display("FAIL rstb_rdv_rst got=%b exp=0", amm_readdatavalid); end
        tick();
        rst = 1'b0;
        #1;
        tests++; if (amm_readdatavalid !== 1'b0) begin fails++; $display("FAIL rstb_rdv_after got=%b exp=0", amm_readdatavalid); end
        tests++; if (proto_err !== 1'b0) begin fails++; $display("FAIL rstb_proto got=%b exp=0", proto_err); end
        tests++; if (amm_waitrequest !== 1'b0) begin fails++; $display("FAIL rstb_wait got=%b exp=0", amm_waitrequest); end
        tick();
        tests++; if (amm_readdatavalid !== 1'b0) begin fails++; $display("FAIL rstb_rdv_tail got=%b exp=0", amm_readdatavalid); end
        single_write(16'h0050, 32'hCAFEF00D, 4'hF);
        amm_read = 1'b1; amm_address = 16'h0050;
        tick();
        tests++; if (amm_readdata !== 32'hCAFEF00D) begin fails++; $display("FAIL rstb_newwr got=%h exp=cafef00d", amm_readdata); end
        amm_address = 16'h0045;
        tick();
        tests++; if (amm_readdata !== 32'hB5) begin fails++; $display("FAIL rstb_keep45 got=%h exp=b5", amm_readdata); end
        amm_address = 16'h0010;
        tick();
        idle_bus();
        tests++; if (amm_readdata !== 32'hDEADBEEF) begin fails++; $display("FAIL rstb_keep10 got=%h exp=deadbeef", amm_readdata); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap_burst();
        test_byteenable();
        test_back_to_back();
        test_gap_proto();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
